// File: rtl/run_sequencer.sv
// -----------------------------------------------------------------------------
// run_sequencer
//   Run-control sequencer for the pipelined ARM core. It holds the core in
//   reset, lets it run until a halt store or a cycle timeout, requests a dump
//   window, and then parks in a sticky DONE state until restarted.
//
//   State flow: RESET_HOLD -> RUN -> DUMP -> DONE -(restart)-> RESET_HOLD
//
// Parameters
//   N             data-memory address/data width
//   CNT_W         cycle counter width
//   RESET_CYCLES  extra reset-hold edges after the first edge seeing reset low
//   MAX_CYCLES    RUN-cycle timeout
//   DUMP_CYCLES   cycles dump stays high
//   HALT_ADDR     store address that signals program halt
//
// Ports
//   CLOCK_50        in   clock, rising-edge
//   reset           in   synchronous active-high reset
//   restart         in   pulse; leaves DONE for a fresh run
//   DM_writeEnable  in   data-memory write strobe (monitored)
//   DM_addr         in   data-memory address (monitored)
//   DM_writeData    in   data-memory write data (monitored)
//   cpu_reset       out  processor reset
//   dump            out  dump request window
//   done            out  sticky run-complete flag
//   halt_cause      out  00 none, 01 timeout, 10 halt store
//   cycle_count     out  completed RUN cycles of the current/last run
//
// Build option
//   RUN_SEQ_HALT_DATA_EN : a halt store additionally needs DM_writeData to be
//                          all-ones; other stores to HALT_ADDR are ordinary.
// -----------------------------------------------------------------------------
module run_sequencer #(
  parameter int               N            = 64,
  parameter int               CNT_W        = 32,
  parameter int               RESET_CYCLES = 2,
  parameter int               MAX_CYCLES   = 5000,
  parameter int               DUMP_CYCLES  = 2,
  parameter logic [N-1:0]     HALT_ADDR    = 'h3F8
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             restart,
  input  logic             DM_writeEnable,
  input  logic [N-1:0]     DM_addr,
  input  logic [N-1:0]     DM_writeData,
  output logic             cpu_reset,
  output logic             dump,
  output logic             done,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int HOLD_W = $clog2(RESET_CYCLES + 1) + 1;
  localparam int DMP_W  = $clog2(DUMP_CYCLES) + 1;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
  localparam logic [1:0] CAUSE_HALT    = 2'b10;

  typedef enum logic [1:0] {
    S_RESET_HOLD = 2'd0,
    S_RUN        = 2'd1,
    S_DUMP       = 2'd2,
    S_DONE       = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [DMP_W-1:0]   dmp_q, dmp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         cause_q, cause_d;
  logic               halt_hit;

  // Halt-store detect. Only meaningful while in RUN; gated in the FSM.
`ifdef RUN_SEQ_HALT_DATA_EN
  assign halt_hit = DM_writeEnable && (DM_addr == HALT_ADDR) &&
                    (DM_writeData == {N{1'b1}});
`else
  logic unused_wdata;
  assign unused_wdata = ^DM_writeData;
  assign halt_hit     = DM_writeEnable && (DM_addr == HALT_ADDR);
`endif

  // Next-state / datapath.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    dmp_d   = dmp_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    unique case (state_q)
      // The edge that enters RESET_HOLD (reset or restart) is not counted;
      // RESET_CYCLES+1 further edges are spent here, so cpu_reset falls
      // RESET_CYCLES edges after the first edge that sees reset low.
      S_RESET_HOLD: begin
        if (hold_q == HOLD_W'(RESET_CYCLES)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      // Count includes the exit edge so it equals the number of RUN cycles.
      // Halt has priority over a coincident timeout.
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (halt_hit) begin
          state_d = S_DUMP;
          cause_d = CAUSE_HALT;
          dmp_d   = '0;
        end else if (cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
          state_d = S_DUMP;
          cause_d = CAUSE_TIMEOUT;
          dmp_d   = '0;
        end
      end
      S_DUMP: begin
        if (dmp_q == DMP_W'(DUMP_CYCLES - 1)) begin
          state_d = S_DONE;
        end else begin
          dmp_d = dmp_q + 1'b1;
        end
      end
      S_DONE: begin
        if (restart) begin
          state_d = S_RESET_HOLD;
          hold_d  = '0;
          cnt_d   = '0;
          cause_d = CAUSE_NONE;
        end
      end
      default: state_d = S_RESET_HOLD;
    endcase
  end

  // State and registered outputs. Outputs are decoded from the next state
  // into flops so no input reaches an output combinationally.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= S_RESET_HOLD;
      hold_q      <= '0;
      dmp_q       <= '0;
      cnt_q       <= '0;
      cause_q     <= CAUSE_NONE;
      cpu_reset   <= 1'b1;
      dump        <= 1'b0;
      done        <= 1'b0;
      halt_cause  <= CAUSE_NONE;
      cycle_count <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      dmp_q       <= dmp_d;
      cnt_q       <= cnt_d;
      cause_q     <= cause_d;
      cpu_reset   <= (state_d == S_RESET_HOLD);
      dump        <= (state_d == S_DUMP);
      done        <= (state_d == S_DONE);
      halt_cause  <= cause_d;
      cycle_count <= cnt_d;
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// -----------------------------------------------------------------------------
// tb_run_sequencer
//   Scoreboard bench for run_sequencer. The driver plans each run (halt cycle
//   or timeout, decoy stores, stray restart, optional reset during DUMP),
//   applies it edge by edge and pushes the expected outputs for each edge.
//   The expected outputs come from a piecewise timeline of the run (hold,
//   run, dump, done phases). A monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_run_sequencer;

  localparam int RC   = 2;
  localparam int MAXC = 5000;
  localparam int DC   = 2;
  localparam logic [63:0] HALT = 64'h3F8;

  typedef struct packed {
    logic        cpu_reset;
    logic        dump;
    logic        done;
    logic [1:0]  cause;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, restart, dm_we;
  logic [63:0] dm_addr, dm_data;
  logic        cpu_reset, dump, done;
  logic [1:0]  halt_cause;
  logic [31:0] cycle_count;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  run_sequencer #(
    .N(64), .CNT_W(32), .RESET_CYCLES(RC), .MAX_CYCLES(MAXC),
    .DUMP_CYCLES(DC), .HALT_ADDR(HALT)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .restart(restart),
    .DM_writeEnable(dm_we), .DM_addr(dm_addr), .DM_writeData(dm_data),
    .cpu_reset(cpu_reset), .dump(dump), .done(done),
    .halt_cause(halt_cause), .cycle_count(cycle_count)
  );

  // Expected outputs after edge j of a run (edge 0 = entering edge).
  // Hold phase spans RC+1 cycles, run phase L cycles, dump DC cycles.
  function automatic exp_t model(input int j, input int len, input logic [1:0] cause);
    exp_t e;
    e = '0;
    if (j <= RC) begin
      e.cpu_reset = 1'b1;
    end else if (j <= RC + len) begin
      e.cnt = 32'(j - RC - 1);
    end else if (j <= RC + len + DC) begin
      e.dump = 1'b1; e.cnt = 32'(len); e.cause = cause;
    end else begin
      e.done = 1'b1; e.cnt = 32'(len); e.cause = cause;
    end
    return e;
  endfunction

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    a = {$urandom, $urandom};
    if (a == HALT) a = a ^ 64'h1;
    return a;
  endfunction

  // k: RUN edge of the halt store (0 = let it time out)
  // decoy: RUN edge of a store to a neighbouring address (0 = none)
  // rs_run: RUN edge carrying a stray restart pulse (0 = none)
  // abort_dump: DUMP cycle (1-based) at which reset is asserted (0 = none)
  task automatic do_run(input bit via_restart, input int k, input int decoy,
                        input int rs_run, input int abort_dump, input int idle);
    int          len;
    logic [1:0]  cause;
    int          fin;
    len   = (k > 0) ? k : MAXC;
    cause = (k > 0) ? 2'b10 : 2'b01;
    fin   = RC + len + DC + 1;
    for (int j = 0; j < fin + idle; j++) begin
      int m;
      bit aborting;
      m        = j - RC - 1;
      reset    = 1'b0;
      restart  = 1'b0;
      dm_we    = 1'($urandom_range(0, 1));
      dm_addr  = rand_addr();
      dm_data  = {$urandom, $urandom};
      if (j == 0) begin
        if (via_restart) restart = 1'b1; else reset = 1'b1;
      end else if (j == 1 || j == fin) begin
        // halt-looking store outside RUN must be ignored
        dm_we = 1'b1; dm_addr = HALT; dm_data = '1;
      end
      if (rs_run > 0 && m == rs_run) restart = 1'b1;
      if (decoy > 0 && m == decoy) begin
        dm_we = 1'b1; dm_addr = 64'h3F0; dm_data = '1;
      end
`ifdef RUN_SEQ_HALT_DATA_EN
      if (decoy > 0 && m == decoy + 1) begin
        dm_we = 1'b1; dm_addr = HALT; dm_data = 64'd5;
      end
`endif
      if (k > 0 && m == k) begin
        dm_we = 1'b1; dm_addr = HALT;
`ifdef RUN_SEQ_HALT_DATA_EN
        dm_data = '1;
`endif
      end
      aborting = (abort_dump > 0) && (j == RC + len + 1 + abort_dump);
      if (aborting) reset = 1'b1;
      @(posedge clk); #1;
      sb.push_back(aborting ? model(0, len, cause) : model(j, len, cause));
      if (aborting) return;
    end
  endtask

  // Monitor: one expectation per edge, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e, g;
      e = sb.pop_front();
      g = '{cpu_reset, dump, done, halt_cause, cycle_count};
      checks++;
      if (g !== e) begin
        errors++;
        if (errors <= 20)
          $display("FAIL outputs t=%0t got cr=%0b dump=%0b done=%0b cause=%b cnt=%0d want cr=%0b dump=%0b done=%0b cause=%b cnt=%0d",
                   $time, g.cpu_reset, g.dump, g.done, g.cause, g.cnt,
                   e.cpu_reset, e.dump, e.done, e.cause, e.cnt);
      end
    end
  end

  initial begin
    int k, d, r;
    reset = 1'b1; restart = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_data = '0;
    @(posedge clk); #1;
    // 2 reset cycles, timeout run with a stray restart mid-RUN
    do_run(1'b0, 0, 0, 2500, 0, 3);
    // halt at RUN cycle 100, decoy store to 3F0 earlier
    do_run(1'b1, 100, 40, 0, 0, 2);
    // halt and timeout on the same edge: halt wins
    do_run(1'b1, MAXC, 0, 0, 0, 2);
    // halt on the very first RUN edge
    do_run(1'b1, 1, 0, 0, 0, 1);
    // reset during DUMP, then a fresh reset-started run
    do_run(1'b1, 30, 10, 5, 1, 0);
    do_run(1'b0, 20, 3, 0, 0, 2);
    // randomized runs
    for (int i = 0; i < 6; i++) begin
      k = $urandom_range(3, 400);
      d = $urandom_range(1, k - 2);
      r = $urandom_range(1, k - 1);
      do_run(1'b1, k, d, r, 0, $urandom_range(1, 4));
    end
    reset = 1'b0; restart = 1'b0; dm_we = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
